// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and the output clamp used by every
// stage that narrows a wide accumulator back to sample width.
package fft_pkg;

  localparam int DATA_W      = 16;
  localparam int TW_W        = 9;
  localparam int TW_FRAC     = 7;
  localparam int PROD_W      = DATA_W + TW_W;
  localparam int SUM_W       = PROD_W + 1;
  localparam int ROUND_CONST = 2 ** (TW_FRAC - 1);

  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2 ** (DATA_W - 1)));

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [SUM_W-1:0] x);
    logic signed [SUM_W-1:0] clamped;
    if (x > SAT_MAX) begin
      clamped = SAT_MAX;
    end else if (x < SAT_MIN) begin
      clamped = SAT_MIN;
    end else begin
      clamped = x;
    end
    return clamped[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fft_twiddle_mul_if.sv
// Sample stream in, product stream out, plus the twiddle ROM lookup path.
interface fft_twiddle_mul_if;
  import fft_pkg::*;

  logic                     in_valid;
  logic                     frame_start;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;
  logic [3:0]               rom_16_counter;
  logic signed [TW_W-1:0]   w_r;
  logic signed [TW_W-1:0]   w_i;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_re;
  logic signed [DATA_W-1:0] out_im;

  modport slave (
    input  in_valid, frame_start, in_re, in_im, w_r, w_i,
    output rom_16_counter, out_valid, out_re, out_im
  );

  modport master (
    output in_valid, frame_start, in_re, in_im, w_r, w_i,
    input  rom_16_counter, out_valid, out_re, out_im
  );
endinterface

// File: rtl/fft_twiddle_mul_cmul_pipe.sv
// Three-stage complex multiplier: operand capture, partial products,
// then add/round/saturate into the output register.
module cmul_pipe
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  input  logic signed [TW_W-1:0]   w_r,
  input  logic signed [TW_W-1:0]   w_i,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im
);

  logic                     v1_reg, v2_reg;
  logic signed [DATA_W-1:0] a_reg, b_reg;
  logic signed [TW_W-1:0]   c_reg, d_reg;
  logic signed [PROD_W-1:0] ac_reg, bd_reg, ad_reg, bc_reg;
  logic signed [SUM_W-1:0]  sum_re, sum_im, rnd_re, rnd_im;

  // Full-width sums; rounding offset is added before the arithmetic shift.
  always_comb begin
    sum_re = SUM_W'(ac_reg) - SUM_W'(bd_reg);
    sum_im = SUM_W'(ad_reg) + SUM_W'(bc_reg);
    rnd_re = (sum_re + SUM_W'(ROUND_CONST)) >>> TW_FRAC;
    rnd_im = (sum_im + SUM_W'(ROUND_CONST)) >>> TW_FRAC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      out_valid <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      d_reg     <= '0;
      ac_reg    <= '0;
      bd_reg    <= '0;
      ad_reg    <= '0;
      bc_reg    <= '0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      v1_reg    <= in_valid;
      a_reg     <= in_re;
      b_reg     <= in_im;
      c_reg     <= w_r;
      d_reg     <= w_i;

      v2_reg    <= v1_reg;
      ac_reg    <= PROD_W'(a_reg) * PROD_W'(c_reg);
      bd_reg    <= PROD_W'(b_reg) * PROD_W'(d_reg);
      ad_reg    <= PROD_W'(a_reg) * PROD_W'(d_reg);
      bc_reg    <= PROD_W'(b_reg) * PROD_W'(c_reg);

      out_valid <= v2_reg;
      out_re    <= saturate(rnd_re);
      out_im    <= saturate(rnd_im);
    end
  end

endmodule

// File: rtl/fft_twiddle_mul.sv
// Twiddle stage: owns the 16-entry ROM address counter and feeds each
// valid sample with its twiddle into the complex multiply pipeline.
module fft_twiddle_mul
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  fft_twiddle_mul_if.slave  bus
);

  logic [3:0] k_reg;
  logic       restart;

  // A frame start overrides the counter in the same cycle so the lookup hits entry 0.
  assign restart            = bus.frame_start & bus.in_valid;
  assign bus.rom_16_counter = restart ? 4'd0 : k_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_reg <= 4'd0;
    end else if (bus.in_valid) begin
      k_reg <= restart ? 4'd1 : k_reg + 4'd1;
    end
  end

  cmul_pipe u_cmul_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_re     (bus.in_re),
    .in_im     (bus.in_im),
    .w_r       (bus.w_r),
    .w_i       (bus.w_i),
    .out_valid (bus.out_valid),
    .out_re    (bus.out_re),
    .out_im    (bus.out_im)
  );

endmodule

// File: tb/tb_fft_twiddle_mul.sv
// Scoreboard bench for the twiddle stage: stimulus pushes model results,
// a negedge monitor pops them whenever out_valid is seen.
module tb_fft_twiddle_mul;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_twiddle_mul_if bus();

  fft_twiddle_mul dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Twiddle ROM stand-in; entry 15 is deliberately extreme to stress saturation.
  int rom_r[16] = '{128, 125, 118, 106, 90, 71, 49, 25, 0, -25, -49, -71, -90, -106, -118, -256};
  int rom_i[16] = '{0, -24, -49, -71, -90, -106, -118, -125, -128, -125, -118, -106, -90, -71, -49, 255};
  assign bus.w_r = TW_W'(rom_r[bus.rom_16_counter]);
  assign bus.w_i = TW_W'(rom_i[bus.rom_16_counter]);

  typedef struct {
    int     re;
    int     im;
    longint due;
    int     addr;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;
  int     exp_k   = 0;
  int     dir_re[16];
  int     dir_im[16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Exact complex product scaled by 1/128, rounded half-up, clipped to 16 bits.
  function automatic int ref_part(input int a, input int b, input int c, input int d, input bit want_im);
    longint s;
    s = want_im ? (longint'(a) * d + longint'(b) * c) : (longint'(a) * c - longint'(b) * d);
    s = (s + 64) >>> 7;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic drive(input bit v, input bit fs, input int re, input int im);
    int   addr;
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid    = v;
    bus.frame_start = fs;
    bus.in_re       = DATA_W'(re);
    bus.in_im       = DATA_W'(im);
    addr = (v && fs) ? 0 : exp_k;
    #1;
    check("rom_addr", longint'(bus.rom_16_counter), addr);
    if (v) begin
      e.re   = ref_part(re, im, rom_r[addr], rom_i[addr], 1'b0);
      e.im   = ref_part(re, im, rom_r[addr], rom_i[addr], 1'b1);
      e.due  = cyc + 3;
      e.addr = addr;
      sb.push_back(e);
      exp_k = fs ? 1 : (exp_k + 1) % 16;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("out_re", longint'(bus.out_re), mon_e.re);
          check("out_im", longint'(bus.out_im), mon_e.im);
          check("latency", cyc, mon_e.due);
          $display("[TB] cyc %0d addr %0d out (%0d, %0d) exp (%0d, %0d)",
                   cyc, mon_e.addr, bus.out_re, bus.out_im, mon_e.re, mon_e.im);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        check("missing_valid", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    int re, im;
    bit v, fs;

    bus.in_valid    = 1'b0;
    bus.frame_start = 1'b0;
    bus.in_re       = '0;
    bus.in_im       = '0;

    #1;
    check("reset_out_valid", longint'(bus.out_valid), 0);
    check("reset_out_re", longint'(bus.out_re), 0);
    check("reset_out_im", longint'(bus.out_im), 0);
    check("reset_rom_addr", longint'(bus.rom_16_counter), 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Directed run: data chosen per ROM address to hit the worked examples.
    for (int i = 0; i < 16; i++) begin
      dir_re[i] = $urandom_range(0, 4000) - 2000;
      dir_im[i] = $urandom_range(0, 4000) - 2000;
    end
    dir_re[0]  = 1000;   dir_im[0]  = -500;
    dir_re[1]  = 1;      dir_im[1]  = 0;
    dir_re[4]  = 128;    dir_im[4]  = 0;
    dir_re[8]  = 1000;   dir_im[8]  = 0;
    dir_re[12] = -32768; dir_im[12] = -32768;

    for (int i = 0; i < 17; i++) begin
      drive(1'b1, i == 0, dir_re[i % 16], dir_im[i % 16]);
      if (i == 5) begin
        for (int j = 0; j < 3; j++) drive(1'b0, 1'b0, 7, 7);
      end
    end

    // Frame start exactly on the wrap sample, then a mid-run restart.
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 300 + i, -300 - i);
    drive(1'b1, 1'b1, 32767, 32767);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, -32768, 32767);
    drive(1'b1, 1'b1, 555, -555);
    drive(1'b0, 1'b0, 0, 0);

    // Randomized traffic with bubbles and stray frame_start pulses.
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 9) < 7);
      fs = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 4) == 0) begin
        re = $urandom_range(0, 1) ? 32767 : -32768;
        im = $urandom_range(0, 1) ? 32767 : -32768;
      end else begin
        re = int'($urandom_range(0, 65535)) - 32768;
        im = int'($urandom_range(0, 65535)) - 32768;
      end
      drive(v, fs, re, im);
    end

    // Let the random traffic drain before the reset test.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 0, 0);

    // Reset with two samples in flight: both must vanish.
    drive(1'b1, 1'b0, 1234, 4321);
    drive(1'b1, 1'b0, -1234, -4321);
    @(posedge clk);
    #2;
    bus.in_valid    = 1'b0;
    bus.frame_start = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    exp_k = 0;
    #1;
    check("midreset_out_valid", longint'(bus.out_valid), 0);
    check("midreset_out_re", longint'(bus.out_re), 0);
    check("midreset_out_im", longint'(bus.out_im), 0);
    check("midreset_rom_addr", longint'(bus.rom_16_counter), 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 1000, -500);
    drive(1'b1, 1'b0, 1, 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) drive(1'b0, 1'b0, 0, 0);
    if (sb.size() > 0) check("drain_timeout", sb.size(), 0);
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
